// File: rtl/spi_slave.sv
// SPI mode-0 responder for the 16-bit link: oversampled sclk/cs/mosi, MSB first, registered miso.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output for truncated words.
module spi_slave #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] data_rx,
    output logic                  rx_valid,
    output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] data_rx_q, data_rx_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  reload_q, reload_d;
    logic                  miso_q, miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                  frame_err_q, frame_err_d;
`endif

    // cs synchronizer resets to the idle (high) level so reset release never looks like a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        data_rx_d  = data_rx_q;
        rx_valid_d = 1'b0;
        reload_d   = reload_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StActive;
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                end
            end
            StActive: begin
                // Frame end wins over any coincident sclk edge; a partial word is dropped.
                if (cs_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_err_d = (bit_cnt_q != '0);
`endif
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-3:0], mosi_s};
                    if (bit_cnt_q == CntMax) begin
                        data_rx_d  = {rx_shift_q, mosi_s};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        tx_shift_d = tx_data;
                        reload_d   = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        miso_d = (state_d == StActive) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            data_rx_q  <= '0;
            rx_valid_q <= 1'b0;
            reload_q   <= 1'b0;
            miso_q     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            data_rx_q  <= data_rx_d;
            rx_valid_q <= rx_valid_d;
            reload_q   <= reload_d;
            miso_q     <= miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign data_rx  = data_rx_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == StActive);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a mode-0 master model against a word-level reference model.
module tb_spi_slave;

    localparam int unsigned W    = 16;
    localparam int unsigned SYNC = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         sclk, cs, mosi, miso;
    logic [W-1:0] tx_data, data_rx;
    logic         rx_valid, busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic         frame_err;
`endif

    spi_slave #(
        .DATA_WIDTH  (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .data_rx  (data_rx),
        .rx_valid (rx_valid),
        .busy     (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int dbl_cnt = 0;
    int ferr_cnt = 0;
    int exp_ferr = 0;
    bit rv_prev = 1'b0;
    logic [W-1:0] got_rx[$];
    logic [W-1:0] m_words[4];
    logic [W-1:0] t_words[4];
    logic [W-1:0] exp_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: collects words, checks latency, counts pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                got_rx.push_back(data_rx);
                check("rx_latency", cyc - last_rise_cyc, SYNC + 1);
                if (rv_prev) dbl_cnt++;
            end
            rv_prev = rx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (frame_err) ferr_cnt++;
`endif
        end else begin
            rv_prev = 1'b0;
        end
    end

    // Master model: 8-clk sclk phases, mosi set mid-low-phase, miso sampled at each rise.
    task automatic run_frame(input int nbits, input bit loop);
        logic [W-1:0] mrx;
        int           nfull, nwords, got0, w, b;
        bit           stable;
        logic         snap;
        nfull  = nbits / W;
        nwords = (nbits + W - 1) / W;
        got0   = got_rx.size();
        stable = 1'b1;
        mrx    = '0;
        tx_data = t_words[0];
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            w = i / W;
            b = W - 1 - (i % W);
            tick(4);
            mosi = loop ? miso : m_words[w][b];
            snap = miso;
            tick(4);
            if (miso !== snap) stable = 1'b0;
            mrx[b] = miso;
            sclk = 1'b1;
            last_rise_cyc = cyc;
            if (i == 0) check("busy_in_frame", busy, 1);
            if (b == 0) check("master_rx_word", mrx, t_words[w]);
            tick(4);
            if (b == 0 && w + 1 < nwords) tx_data = t_words[w + 1];
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
        cs = 1'b1;
        tick(10);
        check("miso_stable", stable, 1);
        check("busy_after", busy, 0);
        check("miso_idle", miso, 0);
        check("rx_count", got_rx.size() - got0, nfull);
        for (int k = 0; k < nfull; k++) begin
            exp_last = loop ? t_words[k] : m_words[k];
            if (got0 + k < got_rx.size()) check("rx_word", got_rx[got0 + k], exp_last);
        end
        check("data_rx_hold", data_rx, exp_last);
        if (nbits % W != 0) exp_ferr++;
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_data = '0;
        exp_last = '0;
        tick(3);
        check("rst_miso", miso, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(4);
        check("init_data_rx", data_rx, 0);
        check("init_rx_valid", rx_valid, 0);

        // Single frame
        m_words[0] = 16'hA5A5; t_words[0] = 16'h3C3C;
        run_frame(16, 1'b0);

        // Reset mid-frame after 7 sclk rises
        cs = 1'b0;
        tick(8);
        for (int i = 0; i < 7; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = 1'b1; tick(8);
            if (i < 6) begin sclk = 1'b0; tick(8); end
        end
        reset = 1'b1;
        #1;
        check("midrst_miso", miso, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data_rx", data_rx, 0);
        tick(2);
        sclk = 1'b0; cs = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_last = '0;
        tick(8);
        m_words[0] = 16'h1234; t_words[0] = 16'h0F0F;
        run_frame(16, 1'b0);

        // Back-to-back words under one cs
        m_words[0] = 16'hA5A5; m_words[1] = 16'h1234;
        t_words[0] = 16'h3C3C; t_words[1] = 16'hBEEF;
        run_frame(32, 1'b0);

        // Truncated frame: 9 bits of 0xFFFF
        m_words[0] = 16'hFFFF; t_words[0] = 16'h8001;
        run_frame(9, 1'b0);
        check("trunc_keeps", data_rx, 16'h1234);

        // Loopback: slave mosi fed from its own miso
        m_words[0] = 16'h5A5A; t_words[0] = 16'h5A5A;
        run_frame(16, 1'b1);

        // Randomized frames, some truncated
        for (int r = 0; r < 6; r++) begin
            int nw, nb;
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                m_words[k] = 16'($urandom);
                t_words[k] = 16'($urandom);
            end
            nb = nw * W;
            if ($urandom_range(0, 2) == 0) nb = nb - $urandom_range(1, W - 1);
            run_frame(nb, 1'b0);
        end

        check("rx_valid_double", dbl_cnt, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err_count", ferr_cnt, exp_ferr);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (responder) end of the team's 16-bit SPI link; the counterpart to the SPI master (clk/reset/start_transfer/sclk/cs/mosi/miso).
- Mode 0 (CPOL=0, CPHA=0), MSB first, cs active-low.
- sclk, cs and mosi are asynchronous inputs, oversampled in the system clock domain.
- Receives one word per frame onto data_rx and shifts tx_data out on miso.

Parameters:
- DATA_WIDTH, 16, word length in bits.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, cs and mosi (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master.
- cs  input  1  chip select from master, active-low.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- tx_data  input  DATA_WIDTH  word to transmit; captured at frame start and at each word boundary.
- data_rx  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  one-clk pulse when data_rx updates.
- busy  output  1  high while a frame is active (synchronized cs low).

Behaviour:
- Reset, asynchronous: miso=0, data_rx=0, rx_valid=0, busy=0, FSM=IDLE, bit counter=0, shift registers=0.
- sclk, cs and mosi each pass through SYNC_STAGES flops. Edges are detected from the last two synchronized samples (rise = prev 0, cur 1).
- Timing constraint: sclk high and low phases must each be at least 4 clk periods. Behaviour is undefined otherwise.
- FSM states:
  - IDLE: busy=0, miso=0.
  - ACTIVE: busy=1.
- IDLE -> ACTIVE on synchronized cs falling edge:
  - tx_shift <= tx_data; bit_cnt <= 0.
  - miso = tx_data[MSB] from the next clk onward, i.e. before the master's first sclk rise.
- In ACTIVE, on synchronized sclk rising edge (sample):
  - rx_shift <= {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
  - If bit_cnt == W-1:
    - data_rx <= {rx_shift[W-2:0], mosi_sync}.
    - rx_valid=1 for exactly one clk.
    - bit_cnt <= 0.
    - reload flag set.
- In ACTIVE, on synchronized sclk falling edge (shift out):
  - If reload flag is set: tx_shift <= tx_data, flag cleared (back-to-back words under one cs).
  - Otherwise: tx_shift <= tx_shift << 1.
- miso = tx_shift[W-1] while ACTIVE, 0 in IDLE. miso is registered, with no combinational path from inputs.
- ACTIVE -> IDLE on synchronized cs rising edge, with priority over a coincident sclk edge:
  - Partial word discarded; data_rx unchanged; no rx_valid.
  - bit_cnt <= 0; reload flag cleared.
- An sclk edge while in IDLE is ignored.
- data_rx holds its value until the next complete word. rx_valid is never asserted for two consecutive clks.
- tx_data may change at any time. Only its value at a capture point (cs fall or reload) matters.
- Latency: rx_valid rises SYNC_STAGES+1 clks after the physical 16th sclk rising edge.
- Counter width: clog2(DATA_WIDTH). Wrap occurs explicitly at W-1, not by overflow.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- With macro defined:
  - Adds output frame_err (1 bit, reset 0).
  - frame_err pulses for one clk when cs deasserts with 0 < bit_cnt < DATA_WIDTH, i.e. a truncated word.
  - A cs rise with bit_cnt == 0 (whole words only) produces no pulse.
- Without macro: port absent; truncated words are silently dropped as above.

Test Plan:
- Reset mid-frame: assert reset after 7 sclk rises -> miso=0, busy=0, data_rx=0000 immediately. The next full frame carrying 0x1234 yields data_rx=0x1234.
- Single frame: master model with sclk = clk/16 sends mosi 0xA5A5, tx_data=0x3C3C -> one rx_valid pulse, data_rx=0xA5A5, master receives 0x3C3C; busy high only while cs low.
- Back-to-back: two words 0xA5A5 then 0x1234 under one cs, tx_data changed to 0xBEEF after the first rx_valid -> two rx_valid pulses, data_rx sequence A5A5 then 1234, master receives 3C3C then BEEF.
- Truncated frame: cs raised after 9 bits of 0xFFFF -> data_rx keeps its prior value (0x1234), no rx_valid. With SPI_SLAVE_FRAME_ERR_EN: exactly one frame_err pulse.
- Loopback: miso tied to the master's mosi, master sends 0x5A5A, tx_data=0x5A5A -> data_rx=0x5A5A and master data_rx=0x5A5A. Glitch-free miso is checked at every sclk rise.
